xor_oper_pipe: RTL and testbench

Multi-channel, pipelined bitwise XOR engine. It accepts CH operand pairs of N bits per beat over a valid/ready handshake and applies one of four per-beat modes, including a running XOR accumulator per channel. Results come out after a fixed LAT-cycle pipeline that stalls under backpressure. It sits between operand sources and checksum or scrambler consumers in the datapath.

---
 rtl/xor_oper_pipe_if.sv | 26 ++
 rtl/xor_oper_pipe.sv | 113 +++++++++++
 tb/tb_xor_oper_pipe.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/xor_oper_pipe_if.sv
// Operand/result handshake bundle for xor_oper_pipe.
// The engine takes the slave view; operand sources and result consumers use master.
interface xor_oper_pipe_if #(
    parameter int N  = 4,
    parameter int CH = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        mode;
    logic [CH*N-1:0]   a;
    logic [CH*N-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [CH*N-1:0]   co;
    logic [CH-1:0]     co_par;

    modport master (
        output in_valid, mode, a, b, out_ready,
        input  in_ready, out_valid, co, co_par
    );

    modport slave (
        input  in_valid, mode, a, b, out_ready,
        output in_ready, out_valid, co, co_par
    );
endinterface

// File: rtl/xor_oper_pipe.sv
// xor_oper_pipe: CH-channel bitwise XOR/XNOR/accumulate engine with a
// stallable fixed-latency pipeline. A result captured in stage 0 on the
// acceptance edge reaches co LAT edges later.
// Optional build macro: XOR_OPER_PIPE_PARITY_EN adds registered per-channel
// parity on co_par; without it co_par is constant 0.

// Per-channel stage-0 logic: operand combine plus the running accumulator.
module xor_oper_lane #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         take,
    input  logic [1:0]   mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] r
);
    logic [N-1:0] acc;
    logic [N-1:0] x;

    assign x = a ^ b;

    // Result for this beat; ACC returns the value acc takes on this edge
    always_comb begin
        r = x;
        case (mode)
            2'd1:    r = ~x;
            2'd2:    r = acc ^ x;
            default: r = x;
        endcase
    end

    // Accumulator moves only on accepted ACC/LOAD beats
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (take) begin
            if (mode == 2'd2)
                acc <= acc ^ x;
            else if (mode == 2'd3)
                acc <= x;
        end
    end
endmodule

module xor_oper_pipe #(
    parameter int N   = 4,
    parameter int CH  = 2,
    parameter int LAT = 3
) (
    input logic           clk,
    input logic           rstn,
    xor_oper_pipe_if.slave bus
);
    logic                     en;
    logic                     take;
    logic [CH-1:0][N-1:0]     r;
    logic [LAT:0]             vld_pipe;
    logic [LAT:0][CH*N-1:0]   dat_pipe;

    // Whole pipe advances unless a valid result is being refused
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    assign take         = bus.in_valid && en;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_lane
            xor_oper_lane #(.N(N)) u_lane (
                .clk  (clk),
                .rstn (rstn),
                .take (take),
                .mode (bus.mode),
                .a    (bus.a[gi*N +: N]),
                .b    (bus.b[gi*N +: N]),
                .r    (r[gi])
            );
        end
    endgenerate

    // Stage 0 captures r on acceptance; bubbles shift through like beats
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[LAT-1:0], take};
            dat_pipe <= {dat_pipe[LAT-1:0], r};
        end
    end

    assign bus.out_valid = vld_pipe[LAT];
    assign bus.co        = dat_pipe[LAT];

`ifdef XOR_OPER_PIPE_PARITY_EN
    logic [CH-1:0] par_q;

    // Parity is formed from the stage feeding co so it lands with co
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_q <= '0;
        end else if (en) begin
            for (int i = 0; i < CH; i++)
                par_q[i] <= ^dat_pipe[LAT-1][i*N +: N];
        end
    end

    assign bus.co_par = par_q;
`else
    assign bus.co_par = '0;
`endif
endmodule

// File: tb/tb_xor_oper_pipe.sv
// Directed bench for xor_oper_pipe with a result scoreboard.
module tb_xor_oper_pipe;
    localparam int N   = 4;
    localparam int CH  = 2;
    localparam int LAT = 3;
    localparam int W   = CH * N;

    typedef struct {
        logic [W-1:0]  co;
        logic [CH-1:0] par;
        int            due;
        bit            lat;
    } exp_t;

    logic clk;
    logic rstn;

    xor_oper_pipe_if #(.N(N), .CH(CH)) bus ();

    xor_oper_pipe #(.N(N), .CH(CH), .LAT(LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int                   n_asrt;
    int                   n_fail;
    int                   cyc;
    exp_t                 q[$];
    logic [CH-1:0][N-1:0] macc;
    bit                   chk_lat;
    bit                   held;
    logic [W-1:0]         held_co;
    logic [CH-1:0]        held_par;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model for one accepted beat; updates the model accumulator
    task automatic model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [CH-1:0] p);
        logic [N-1:0] x;
        for (int i = 0; i < CH; i++) begin
            x = a[i*N +: N] ^ b[i*N +: N];
            case (m)
                2'd0: r[i*N +: N] = x;
                2'd1: r[i*N +: N] = ~x;
                2'd2: begin macc[i] = macc[i] ^ x; r[i*N +: N] = macc[i]; end
                default: begin macc[i] = x; r[i*N +: N] = x; end
            endcase
`ifdef XOR_OPER_PIPE_PARITY_EN
            p[i] = ^r[i*N +: N];
`else
            p[i] = 1'b0;
`endif
        end
    endtask

    // One clock: check outputs / record acceptance at negedge, then cross posedge
    task automatic step(output bit took);
        exp_t e;
        @(negedge clk);
        if (held) begin
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_co", {24'd0, bus.co}, {24'd0, held_co});
            chk("hold_par", {30'd0, bus.co_par}, {30'd0, held_par});
        end
        if (bus.out_valid && !bus.out_ready) begin
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            held     = 1'b1;
            held_co  = bus.co;
            held_par = bus.co_par;
        end else begin
            held = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("spurious_out", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("co", {24'd0, bus.co}, {24'd0, e.co});
                chk("co_par", {30'd0, bus.co_par}, {30'd0, e.par});
                if (e.lat) chk("latency", cyc, e.due);
            end
        end
        took = bus.in_valid && bus.in_ready;
        if (took) begin
            model(bus.mode, bus.a, bus.b, e.co, e.par);
            e.due = cyc + 1 + LAT;
            e.lat = chk_lat;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic beat(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        bit t;
        int n;
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.a        = a;
        bus.b        = b;
        n = 0;
        do begin
            step(t);
            n++;
        end while (!t && n < 50);
        if (!t) chk("beat_timeout", n, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit t;
        bus.in_valid = 1'b0;
        repeat (n) step(t);
    endtask

    initial begin
        bit   t;
        int   sent;
        int   stalls;
        logic [7:0] pat;

        n_asrt = 0; n_fail = 0; cyc = 0; chk_lat = 1'b1; held = 1'b0;
        macc = '0;
        rstn = 1'b0;
        bus.in_valid = 1'b0; bus.mode = 2'd0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_co", {24'd0, bus.co}, 32'd0);
        chk("rst_co_par", {30'd0, bus.co_par}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single XOR beat, XNOR beat
        beat(2'd0, 8'h5A, 8'h3C);
        idle(6);
        beat(2'd1, 8'h00, 8'h0F);
        idle(6);
        chk("drain_basic", q.size(), 0);

        // LOAD then two chained ACC beats back-to-back
        beat(2'd3, 8'h12, 8'h00);
        beat(2'd2, 8'h34, 8'h00);
        beat(2'd2, 8'h0F, 8'hF0);
        chk("acc_model", {24'd0, macc}, 32'hD9);
        idle(6);

        // Backpressure: 5 XOR beats, out_ready low for 4 cycles while valid
        chk_lat = 1'b0;
        sent = 0; stalls = 0; t = 1'b1;
        for (int c = 0; c < 60 && (sent < 5 || q.size() != 0); c++) begin
            if (sent < 5) begin
                if (t) begin
                    bus.a    = W'($urandom);
                    bus.b    = W'($urandom);
                    bus.mode = 2'd0;
                end
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid && stalls < 4) begin
                bus.out_ready = 1'b0;
                stalls++;
            end else begin
                bus.out_ready = 1'b1;
            end
            step(t);
            if (t) sent++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_stalls", stalls, 4);
        chk("bp_drain", q.size(), 0);
        chk_lat = 1'b1;
        // Accumulator must have survived the stall untouched
        beat(2'd2, 8'h01, 8'h00);
        idle(6);

        // Reset with two beats in flight
        beat(2'd0, 8'hA5, 8'h0F);
        beat(2'd0, 8'h3C, 8'hC3);
        idle(2);
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_co", {24'd0, bus.co}, 32'd0);
        chk("midrst_co_par", {30'd0, bus.co_par}, 32'd0);
        q.delete();
        macc = '0;
        held = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        idle(6);
        beat(2'd2, 8'h11, 8'h00);
        idle(6);

        // Idle gaps: output valid pattern follows the input pattern
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = pat[i];
            bus.mode     = 2'($urandom_range(0, 3));
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            step(t);
        end
        idle(8);
        chk("final_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
